// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte transmitter.
//  - FSM state encodings (2-bit) and the matching enum type.
//  - SPI mode constants (mode 0: clock idles low, data sampled on rising edge).
//  - Default payload width and a width helper for counters.
package spi_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Mode 0: sck idles low, panel samples mosi on the rising edge.
  localparam int SPI_CPOL = 0;
  localparam int SPI_CPHA = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_LINGER = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    SHIFT  = ST_SHIFT,
    LINGER = ST_LINGER
  } spi_state_e;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register for the SPI transmitter.
// Ports:
//  clk, rst   : system clock, synchronous active-high reset (clears to 0).
//  en         : clock-enable; nothing changes while low.
//  load       : on an enabled edge, capture load_data (takes priority over shift).
//  shift      : on an enabled edge, move every bit one place towards the MSB.
//  load_data  : parallel word to transmit.
//  bit_out    : current MSB, i.e. the bit presently driven onto the line.
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             bit_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) begin
      if (load) begin
        data_d = load_data;
      end else if (shift) begin
        data_d = {data_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bit_out = data_q[WIDTH-1];

endmodule

// File: rtl/spi_byte_tx.sv
// SPI mode-0 transmitter for the LCD sequencer.
// Takes one {dc, payload} word per start/done handshake and sends the payload
// MSB-first on sck/mosi, framed by an active-low cs. cs is held low for
// CS_LINGER en-ticks after each word so back-to-back words form one burst.
//
// Handshake: start is sampled only on en ticks while busy=0 (IDLE or LINGER);
// that tick latches data_in and raises busy. done is high for exactly one
// en-period after the last bit; a start seen on that same tick chains the next
// word without releasing cs.
//
// Ports:
//  clk, rst   : system clock, synchronous active-high reset.
//  en         : clock-enable tick; all state advances only when high.
//  start      : request to send data_in.
//  data_in    : [DATA_WIDTH]=dc (0=cmd, 1=data), [DATA_WIDTH-1:0]=payload.
//  done       : one en-period pulse after the final bit.
//  busy       : high from load until done.
//  sck, mosi  : SPI clock (idle low) and serial data.
//  cs         : chip select, active low.
//  dc         : data/command line, stable for the whole word.
//  state_dbg  : current FSM state, for observation only.
module spi_byte_tx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CS_LINGER  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [DATA_WIDTH:0]   data_in,
  output logic                  done,
  output logic                  busy,
  output logic                  sck,
  output logic                  mosi,
  output logic                  cs,
  output logic                  dc,
  output logic [1:0]            state_dbg
);

  localparam int BCW = clog2_min1(DATA_WIDTH);
  localparam int LCW = clog2_min1(CS_LINGER + 1);

  localparam logic [BCW-1:0] BIT_LAST    = BCW'(DATA_WIDTH - 1);
  localparam logic [LCW-1:0] LINGER_INIT = LCW'(CS_LINGER);

  spi_state_e     state_q,      state_d;
  logic [BCW-1:0] bit_cnt_q,    bit_cnt_d;
  logic [LCW-1:0] linger_cnt_q, linger_cnt_d;
  logic           phase_q,      phase_d;
  logic           cs_q,         cs_d;
  logic           sck_q,        sck_d;
  logic           dc_q,         dc_d;
  logic           done_q,       done_d;
  logic           busy_q,       busy_d;

  logic           sr_load;
  logic           sr_shift;
  logic           sr_bit;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    linger_cnt_d = linger_cnt_q;
    phase_d      = phase_q;
    cs_d         = cs_q;
    sck_d        = sck_q;
    dc_d         = dc_q;
    done_d       = done_q;
    busy_d       = busy_q;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sr_load = 1'b1;
            cs_d    = 1'b0;
            dc_d    = data_in[DATA_WIDTH];
            busy_d  = 1'b1;
            state_d = SETUP;
          end
        end

        // One tick of cs-to-sck setup; mosi already carries the MSB.
        SETUP: begin
          phase_d   = 1'b0;
          bit_cnt_d = BIT_LAST;
          state_d   = SHIFT;
        end

        // phase 0 raises sck (panel samples), phase 1 lowers it and moves
        // mosi to the next bit, so mosi only ever changes with sck low.
        SHIFT: begin
          if (!phase_q) begin
            sck_d   = 1'b1;
            phase_d = 1'b1;
          end else begin
            sck_d   = 1'b0;
            phase_d = 1'b0;
            if (bit_cnt_q != '0) begin
              sr_shift  = 1'b1;
              bit_cnt_d = bit_cnt_q - 1'b1;
            end else begin
              done_d       = 1'b1;
              busy_d       = 1'b0;
              linger_cnt_d = LINGER_INIT;
              state_d      = LINGER;
            end
          end
        end

        // cs stays low waiting for a chained word. A load here skips SETUP:
        // the load tick itself provides the mosi setup before the next rise.
        LINGER: begin
          done_d = 1'b0;
          if (start) begin
            sr_load   = 1'b1;
            dc_d      = data_in[DATA_WIDTH];
            busy_d    = 1'b1;
            phase_d   = 1'b0;
            bit_cnt_d = BIT_LAST;
            state_d   = SHIFT;
          end else if (linger_cnt_q == '0) begin
            cs_d    = 1'b1;
            state_d = IDLE;
          end else begin
            linger_cnt_d = linger_cnt_q - 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      linger_cnt_q <= '0;
      phase_q      <= 1'b0;
      cs_q         <= 1'b1;
      sck_q        <= 1'(SPI_CPOL);
      dc_q         <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      linger_cnt_q <= linger_cnt_d;
      phase_q      <= phase_d;
      cs_q         <= cs_d;
      sck_q        <= sck_d;
      dc_q         <= dc_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  spi_shift_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (data_in[DATA_WIDTH-1:0]),
    .bit_out   (sr_bit)
  );

  assign done      = done_q;
  assign busy      = busy_q;
  assign sck       = sck_q;
  assign mosi      = sr_bit;
  assign cs        = cs_q;
  assign dc        = dc_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_byte_tx.sv
module tb_spi_byte_tx;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start;
  logic [8:0] data_in;
  logic       done;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       cs;
  logic       dc;
  logic [1:0] state_dbg;

  spi_byte_tx dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .data_in   (data_in),
    .done      (done),
    .busy      (busy),
    .sck       (sck),
    .mosi      (mosi),
    .cs        (cs),
    .dc        (dc),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / en ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic en_freeze;
  initial begin
    en = 1'b0;
    forever begin
      @(negedge clk);
      if (en_freeze) en = 1'b0;
      else           en = ~en;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  bit   mon_on = 0;
  int   tick_cnt = 0;
  int   done_cnt = 0;
  int   last_done_tick = 0;
  int   cs_rise_cnt = 0;
  int   last_cs_rise_tick = 0;
  int   tot_rises = 0;
  int   words_rx = 0;
  int   n_pushed = 0;
  int   last_start_tick = 0;
  int   word_bits = 0;
  logic       word_dc = 1'b0;
  logic [7:0] byte_acc = 8'h00;
  logic cs_prev = 1'b1, sck_prev = 1'b0, mosi_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait budget expired", nm);
  endtask

  // ---------------- monitor: samples at en ticks, between edges ----------------
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_on && !rst && en) begin
        tick_cnt++;
        if (done) begin
          done_cnt++;
          last_done_tick = tick_cnt;
        end
        if (!cs_prev && cs) begin
          cs_rise_cnt++;
          last_cs_rise_tick = tick_cnt;
        end
        if (sck && !sck_prev) begin
          check("cs_low_at_rise", cs, 0);
          check("mosi_hold_at_rise", mosi, mosi_prev);
        end
        if (cs) begin
          word_bits = 0;
        end else if (sck && !sck_prev) begin
          tot_rises++;
          if (word_bits == 0) word_dc = dc;
          else check("dc_stable", dc, word_dc);
          byte_acc = {byte_acc[6:0], mosi};
          word_bits++;
          if (word_bits == 8) begin
            word_bits = 0;
            words_rx++;
            if (exp_q.size() == 0) begin
              timeout("unexpected_word");
            end else begin
              e = exp_q.pop_front();
              check("word", {word_dc, byte_acc}, e);
            end
          end
        end
        cs_prev   = cs;
        sck_prev  = sck;
        mosi_prev = mosi;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns 2 time units after a negedge whose following posedge has en=1.
  task automatic next_slot();
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!en && n < 200);
    if (!en) timeout("next_slot");
  endtask

  task automatic issue(input logic [8:0] w);
    int n = 0;
    next_slot();
    while (busy && n < 300) begin
      next_slot();
      n++;
    end
    if (busy) timeout("issue_wait");
    start   = 1'b1;
    data_in = w;
    last_start_tick = tick_cnt;
    exp_q.push_back(w);
    n_pushed++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    next_slot();
    while (!(cs && !busy && state_dbg == 2'd0) && n < 300) begin
      next_slot();
      n++;
    end
    if (n >= 300) timeout("wait_idle");
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    next_slot();
    while (tot_rises < target && n < 300) begin
      next_slot();
      n++;
    end
    if (tot_rises < target) timeout("wait_rises");
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    next_slot();
    while (done_cnt < target && n < 300) begin
      next_slot();
      n++;
    end
    if (done_cnt < target) timeout("wait_done");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, c0, r0, changes;
    logic [7:0] snap;

    rst = 1'b1;
    start = 1'b0;
    data_in = 9'h000;
    en_freeze = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_cs",    cs,    1);
    check("rst_sck",   sck,   0);
    check("rst_mosi",  mosi,  0);
    check("rst_dc",    dc,    0);
    check("rst_done",  done,  0);
    check("rst_busy",  busy,  0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    mon_on = 1;

    // Isolated command word: latency and cs linger
    wait_idle();
    d0 = done_cnt;
    issue(9'h0A5);
    wait_done(d0 + 1);
    check("done_latency", last_done_tick - last_start_tick, 18);
    wait_idle();
    check("cs_linger", last_cs_rise_tick - last_done_tick, 3);
    check("single_done", done_cnt, d0 + 1);

    // Burst with start held through the word into LINGER
    wait_idle();
    d0 = done_cnt;
    c0 = cs_rise_cnt;
    r0 = tot_rises;
    next_slot();
    start   = 1'b1;
    data_in = 9'h1F8;
    exp_q.push_back(9'h1F8);
    exp_q.push_back(9'h100);
    n_pushed += 2;
    @(negedge clk);
    data_in = 9'h100;
    wait_done(d0 + 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(d0 + 2);
    check("burst_cs_held", cs_rise_cnt, c0);
    wait_idle();
    check("burst_rises", tot_rises - r0, 16);
    check("burst_dones", done_cnt, d0 + 2);

    // Command then data back to back: dc switches between words
    wait_idle();
    c0 = cs_rise_cnt;
    d0 = done_cnt;
    issue(9'h02A);
    issue(9'h100);
    wait_done(d0 + 2);
    check("cmd_data_cs_held", cs_rise_cnt, c0);
    wait_idle();

    // Reset mid-word after the third rise
    d0 = done_cnt;
    r0 = tot_rises;
    issue(9'h1C7);
    wait_rises(r0 + 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_cs",   cs,   1);
    check("abort_sck",  sck,  0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    void'(exp_q.pop_back());
    n_pushed--;
    wait_idle();
    check("abort_no_done", done_cnt, d0);
    d0 = done_cnt;
    issue(9'h15A);
    wait_done(d0 + 1);
    wait_idle();

    // en held low mid-word
    r0 = tot_rises;
    issue(9'h0E1);
    wait_rises(r0 + 4);
    en_freeze = 1'b1;
    @(negedge clk);
    #3;
    snap = {cs, sck, mosi, dc, done, busy, state_dbg};
    changes = 0;
    repeat (50) begin
      @(negedge clk);
      #1;
      if ({cs, sck, mosi, dc, done, busy, state_dbg} !== snap) changes++;
    end
    check("freeze_changes", changes, 0);
    en_freeze = 1'b0;
    wait_idle();
    check("freeze_rises", tot_rises - r0, 8);

    // start pulsed during SHIFT with other data is ignored
    r0 = tot_rises;
    d0 = done_cnt;
    issue(9'h0C3);
    wait_rises(r0 + 2);
    start   = 1'b1;
    data_in = 9'h13C;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("ignored_start_dones", done_cnt, d0 + 1);
    check("ignored_start_rises", tot_rises - r0, 8);

    repeat (6) next_slot();
    check("words_received", words_rx, n_pushed);
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
